// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and its downstream neighbours.
//   INSTR_WIDTH  - instruction word width
//   NOP_INSTR    - word presented to the decoder when no instruction is available
//   fetchState_t - fetch FSM encoding (IDLE / REQ / DROP)
package cpu_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    REQ  = 2'd1,  // request at PC, data will be kept
    DROP = 2'd2   // request at a pre-flush address, data will be discarded
  } fetchState_t;
endpackage

// File: rtl/instr_queue.sv
// instr_queue: 2-entry FIFO of {instruction, pc}.
//   push/pushInstr/pushPc - enqueue (caller guarantees room)
//   pop                   - dequeue head (caller guarantees non-empty)
//   clear                 - drop all entries, wins over push/pop
//   count                 - occupancy 0..2
//   headValid/headInstr/headPc - head entry; NOP and pc 0 when empty
module instr_queue
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [INSTR_WIDTH-1:0] pushInstr,
  input  logic [ADDR_WIDTH-1:0]  pushPc,
  output logic [1:0]             count,
  output logic                   headValid,
  output logic [INSTR_WIDTH-1:0] headInstr,
  output logic [ADDR_WIDTH-1:0]  headPc
);
  logic [1:0][INSTR_WIDTH-1:0] instrQ;
  logic [1:0][ADDR_WIDTH-1:0]  pcQ;
  logic                        wrIdx;

  // Slot 0 is always the head. A push lands after whatever survives this
  // cycle's pop, so it goes to slot 1 only if one entry remains.
  always_comb wrIdx = (count == 2'd2) || (count == 2'd1 && !pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      instrQ <= '0;
      pcQ    <= '0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      if (pop) begin
        instrQ[0] <= instrQ[1];
        pcQ[0]    <= pcQ[1];
      end
      // Later assignment overrides the shift when writing slot 0.
      if (push) begin
        instrQ[wrIdx] <= pushInstr;
        pcQ[wrIdx]    <= pushPc;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign headValid = (count != 2'd0);
  assign headInstr = headValid ? instrQ[0] : NOP_INSTR;
  assign headPc    = headValid ? pcQ[0] : '0;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage feeding the control decoder.
//   clk, rst_n            - clock, async active-low reset
//   stallIn               - downstream holds the head word
//   flushIn, targetIn     - discard queue/outstanding fetch, redirect PC
//   imemReqOut/AddrOut    - registered memory request, stable until acked
//   imemAckIn/DataIn      - memory completion for the current request
//   instructionOut/pcOut/validOut - queue head (NOP/0/0 when empty)
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stallIn,
  input  logic                   flushIn,
  input  logic [ADDR_WIDTH-1:0]  targetIn,
  output logic                   imemReqOut,
  output logic [ADDR_WIDTH-1:0]  imemAddrOut,
  input  logic                   imemAckIn,
  input  logic [INSTR_WIDTH-1:0] imemDataIn,
  output logic [INSTR_WIDTH-1:0] instructionOut,
  output logic [ADDR_WIDTH-1:0]  pcOut,
  output logic                   validOut
);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;

  fetchState_t           state;
  logic [ADDR_WIDTH-1:0] pc, pcInc;
  logic [1:0]            count, countNext;
  logic                  ackTaken, push, pop;

  always_comb begin
    ackTaken  = imemAckIn & imemReqOut;  // acks without a request are ignored
    pop       = validOut & ~stallIn & ~flushIn;
    push      = (state == REQ) & ackTaken & ~flushIn;
    countNext = count + {1'b0, push} - {1'b0, pop};
    pcInc     = pc + PC_ONE;
  end

  instr_queue #(.ADDR_WIDTH(ADDR_WIDTH)) uQueue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .clear    (flushIn),
    .pushInstr(imemDataIn),
    .pushPc   (imemAddrOut),
    .count    (count),
    .headValid(validOut),
    .headInstr(instructionOut),
    .headPc   (pcOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imemReqOut  <= 1'b0;
      imemAddrOut <= RESET_PC;
    end else if (flushIn) begin
      pc <= targetIn;
      if (state == IDLE || ackTaken) begin
        // Nothing left in flight: start fetching the target right away.
        state       <= REQ;
        imemReqOut  <= 1'b1;
        imemAddrOut <= targetIn;
      end else begin
        // Transaction still open: keep request/address stable, eat its data.
        state <= DROP;
      end
    end else begin
      unique case (state)
        IDLE: if (countNext <= 2'd1) begin
          state       <= REQ;
          imemReqOut  <= 1'b1;
          imemAddrOut <= pc;
        end
        REQ: if (ackTaken) begin
          pc <= pcInc;
          if (countNext == 2'd2) begin
            state      <= IDLE;
            imemReqOut <= 1'b0;
          end else begin
            imemAddrOut <= pcInc;
          end
        end
        DROP: if (ackTaken) begin
          // Queue was cleared by the flush, so there is always room.
          state       <= REQ;
          imemAddrOut <= pc;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized bench for instruction_fetch against a
// transaction-level model (expected queue contents, open-request flag,
// discard flag). A second instance with RESET_PC=FFFF checks PC wrap.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [15:0] target = '0;
  logic        req, ack = 1'b0;
  logic [15:0] addr;
  logic [31:0] data = '0;
  logic [31:0] instr;
  logic [15:0] pcO;
  logic        valid;

  logic        wStall = 1'b0, wFlush = 1'b0, wAck = 1'b0;
  logic [15:0] wTarget = '0;
  logic [31:0] wData = '0;
  logic        wReq, wValid;
  logic [15:0] wAddr, wPc;
  logic [31:0] wInstr;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stallIn(stall), .flushIn(flush), .targetIn(target),
    .imemReqOut(req), .imemAddrOut(addr), .imemAckIn(ack), .imemDataIn(data),
    .instructionOut(instr), .pcOut(pcO), .validOut(valid));

  instruction_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFF)) dutW (
    .clk(clk), .rst_n(rst_n), .stallIn(wStall), .flushIn(wFlush), .targetIn(wTarget),
    .imemReqOut(wReq), .imemAddrOut(wAddr), .imemAckIn(wAck), .imemDataIn(wData),
    .instructionOut(wInstr), .pcOut(wPc), .validOut(wValid));

  int nChk = 0, nErr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { logic [31:0] ins; logic [15:0] pc; } ent_t;
  ent_t        mq[$];
  logic        mReq, mDrop;
  logic [15:0] mAddr, mPc;

  // Memory responder state
  int lat = 1, waitCnt = 0;
  bit spur = 1'b0;

  task automatic modelReset();
    mq.delete();
    mReq = 1'b0; mDrop = 1'b0; mAddr = 16'h0; mPc = 16'h0;
    waitCnt = 0;
  endtask

  // Called at a negedge: compare, drive the next edge's inputs, advance model.
  task automatic step(input bit st, input bit fl, input logic [15:0] tgt);
    bit ackd, open;
    chk("req", {31'b0, req}, {31'b0, mReq});
    if (mReq) chk("addr", {16'b0, addr}, {16'b0, mAddr});
    chk("valid", {31'b0, valid}, {31'b0, mq.size() > 0});
    chk("instr", instr, mq.size() > 0 ? mq[0].ins : 32'h0);
    chk("pc", {16'b0, pcO}, mq.size() > 0 ? {16'b0, mq[0].pc} : 32'h0);

    stall = st; flush = fl; target = tgt;
    if (req) ack = (waitCnt >= lat - 1);
    else     ack = spur && ($urandom_range(0, 3) == 0);
    data = ack ? 32'h100 + {16'b0, addr} : $urandom;
    wAck = wReq; wData = 32'h100 + {16'b0, wAddr};

    ackd = mReq && ack;
    if (fl) begin
      mq.delete();
      mPc = tgt;
      if (mReq && !ackd) mDrop = 1'b1;
      else begin mReq = 1'b1; mAddr = tgt; mDrop = 1'b0; end
    end else begin
      if (mq.size() > 0 && !st) void'(mq.pop_front());
      if (ackd && !mDrop) begin
        mq.push_back('{ins: data, pc: mAddr});
        mPc = mPc + 16'h1;
      end
      if (ackd) mDrop = 1'b0;
      open = mReq && !ackd;
      if (!open) begin
        mReq  = (mq.size() <= 1);
        mAddr = mPc;
      end
    end

    if (req) waitCnt = ack ? 0 : waitCnt + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] wExp [3];
  int seen;

  initial begin
    wExp = '{16'hFFFF, 16'h0000, 16'h0001};
    modelReset();
    repeat (3) @(negedge clk);
    chk("rstReq", {31'b0, req}, 32'h0);
    chk("rstAddr", {16'b0, addr}, 32'h0);
    chk("rstValid", {31'b0, valid}, 32'h0);
    chk("rstWAddr", {16'b0, wAddr}, 32'h0000FFFF);
    rst_n = 1'b1;

    // Zero-wait memory, no stall; also PC wrap on the second instance.
    lat = 1;
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0, 16'h0);
      chk("wrapAddr", {16'b0, wAddr}, {16'b0, wExp[k-1]});
      if (k == 2) begin
        chk("wrapInstr", wInstr, 32'h000100FF);
        chk("wrapPc", {16'b0, wPc}, 32'h0000FFFF);
      end
      if (k == 3) begin
        chk("wrapInstr2", wInstr, 32'h00000100);
        chk("wrapPc2", {16'b0, wPc}, 32'h0);
      end
    end
    repeat (15) step(1'b0, 1'b0, 16'h0);

    // 3-cycle memory latency
    lat = 3;
    repeat (20) step(1'b0, 1'b0, 16'h0);

    // Stall 5 cycles with zero-wait memory, then release
    lat = 1;
    repeat (3) step(1'b0, 1'b0, 16'h0);
    repeat (5) step(1'b1, 1'b0, 16'h0);
    chk("fullNoReq", {31'b0, req}, 32'h0);
    repeat (8) step(1'b0, 1'b0, 16'h0);

    // Flush to 0x40 while a slow request is open (its ack arrives later)
    lat = 3;
    for (int i = 0; i < 10 && !(req && waitCnt == 1); i++) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0040);
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      if (valid) begin
        chk("redirect", {16'b0, pcO}, 32'h40 + seen);
        seen++;
      end
      step(1'b0, 1'b0, 16'h0);
    end
    chk("redirectSeen", seen, 2);

    // Flush coincident with an ack and a pending pop
    lat = 1;
    repeat (4) step(1'b0, 1'b0, 16'h0);
    chk("preFlushValid", {31'b0, valid}, 32'h1);
    step(1'b0, 1'b1, 16'h0080);
    chk("flushNop", instr, 32'h0);
    chk("flushValid", {31'b0, valid}, 32'h0);
    chk("flushTgt", {16'b0, addr}, 32'h80);
    repeat (3) step(1'b0, 1'b0, 16'h0);

    // Random mix: latency, stalls, flushes, spurious acks while idle
    spur = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 3);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, 16'($urandom));
    end
    spur = 1'b0;

    // Reset asserted mid-request
    lat = 3;
    for (int i = 0; i < 10 && !req; i++) step(1'b0, 1'b0, 16'h0);
    stall = 1'b0; flush = 1'b0; ack = 1'b0; wAck = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midRstReq", {31'b0, req}, 32'h0);
    chk("midRstAddr", {16'b0, addr}, 32'h0);
    chk("midRstInstr", instr, 32'h0);
    chk("midRstPc", {16'b0, pcO}, 32'h0);
    chk("midRstValid", {31'b0, valid}, 32'h0);
    chk("midRstWReq", {31'b0, wReq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    lat = 1;
    repeat (10) step(1'b0, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule
